uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_tx_fsm.sv | 76 +++++++
 rtl/uart_tx.sv | 110 +++++++++++
 tb/tb_uart_tx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and receiver: default line
// settings, the transmitter state encoding and the tx output select.
package uart_pkg;

  localparam int unsigned DEF_CLK_HZ    = 25_000_000;
  localparam int unsigned DEF_BAUD_RATE = 9600;
  localparam int unsigned DEF_DATA_BITS = 9;

  // Transmitter FSM states, in frame order.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // What the registered tx line shows during the next cycle.
  typedef enum logic [1:0] {
    TX_MARK  = 2'd0,  // line high: idle or stop bit
    TX_SPACE = 2'd1,  // line low: start bit
    TX_SHIFT = 2'd2   // shift register MSB: data bit
  } tx_sel_e;

  // Counter width for a counter running 0..n-1, never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fsm.sv
// Frame sequencer for uart_tx. Walks IDLE -> START -> DATA -> STOP and
// produces the datapath strobes. tx_sel is decoded from the next state so
// that the registered tx line changes on the same edge as the state.
module uart_tx_fsm
  import uart_pkg::*;
(
  input  logic    clock,
  input  logic    reset_n,
  input  logic    bit_tick,        // cycle counter at its terminal count
  input  logic    last_bit,        // bit counter == DATA_BITS-1
  input  logic    send,
  output logic    load,            // capture data, start a frame
  output logic    shift,           // advance the shift register one bit
  output logic    en_bit_counter,  // count a completed data bit
  output tx_sel_e tx_sel,
  output logic    ready,
  output logic    done
);

  tx_state_e state, state_next;

  // State register plus the one-cycle done pulse on the STOP -> IDLE edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so register order never matters.
      state <= state_next;
      done  <= (state == STOP) && bit_tick;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
    state_next     = state;
    load           = 1'b0;
    shift          = 1'b0;
    en_bit_counter = 1'b0;
    unique case (state)
      IDLE: begin
        if (send) begin
          load       = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (bit_tick) state_next = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift          = 1'b1;
          en_bit_counter = 1'b1;
          if (last_bit) state_next = STOP;
        end
      end
      STOP: begin
        if (bit_tick) state_next = IDLE;
      end
    endcase
  end

  // Line select for the cycle following this edge.
  always_comb begin
    tx_sel = TX_MARK;
    unique case (state_next)
      IDLE, STOP: tx_sel = TX_MARK;
      START:      tx_sel = TX_SPACE;
      DATA:       tx_sel = TX_SHIFT;
    endcase
  end

  assign ready = (state == IDLE);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, DATA_BITS data bits MSB first, 1 stop bit.
// Holds the bit-period and bit counters, the shift register and the
// registered tx line; sequencing lives in uart_tx_fsm.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ    = DEF_CLK_HZ,
  parameter int unsigned BAUD_RATE = DEF_BAUD_RATE,
  parameter int unsigned DATA_BITS = DEF_DATA_BITS
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 send,
  output logic                 ready,
  output logic                 tx,
  output logic                 done
);

  localparam int unsigned BIT_CYCLES = CLK_HZ / BAUD_RATE;
  localparam int unsigned CNT_W      = cnt_width(BIT_CYCLES);
  localparam int unsigned BIT_W      = cnt_width(DATA_BITS);

  logic [CNT_W-1:0]     cycle_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_d;
  logic                 tx_d;
  logic                 bit_tick;
  logic                 last_bit;
  logic                 load;
  logic                 shift;
  logic                 en_bit_counter;
  tx_sel_e              tx_sel;

  assign bit_tick = (cycle_cnt == CNT_W'(BIT_CYCLES - 1));
  assign last_bit = (bit_cnt == BIT_W'(DATA_BITS - 1));

  uart_tx_fsm u_fsm (
    .clock          (clock),
    .reset_n        (reset_n),
    .bit_tick       (bit_tick),
    .last_bit       (last_bit),
    .send           (send),
    .load           (load),
    .shift          (shift),
    .en_bit_counter (en_bit_counter),
    .tx_sel         (tx_sel),
    .ready          (ready),
    .done           (done)
  );

  // Bit-period counter: parked at 0 while idle (which also covers the clear
  // on accept), wraps at BIT_CYCLES-1 while a frame is in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt <= '0;
    end else if (ready || bit_tick) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

  // Data bit counter: cleared on accept, counts bits as they complete.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
    end else if (load) begin
      bit_cnt <= '0;
    end else if (en_bit_counter) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Next shift register value: data is captured only on accept, so later
  // changes on the data port cannot disturb the frame in flight.
  always_comb begin
    shift_d = shift_reg;
    if (load) begin
      shift_d = data;
    end else if (shift) begin
      shift_d = shift_reg << 1;
    end
  end

  // Next line value, taken from the post-edge shift register so the new
  // data bit appears on the same edge as the bit boundary.
  always_comb begin
    tx_d = 1'b1;
    unique case (tx_sel)
      TX_MARK:  tx_d = 1'b1;
      TX_SPACE: tx_d = 1'b0;
      TX_SHIFT: tx_d = shift_d[DATA_BITS-1];
      default:  tx_d = 1'b1;
    endcase
  end

  // Shift register and registered tx line; reset drives the line to mark.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      tx        <= 1'b1;
    end else begin
      shift_reg <= shift_d;
      tx        <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx. A fast instance (16 clocks per bit) gets the
// detailed waveform tests; a default-rate instance is decoded by a
// mid-bit-sampling receiver model. Expected words go into a scoreboard queue
// when a send is driven and are popped when a frame is decoded.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int unsigned NB      = 9;
  localparam int unsigned BC      = 16;
  localparam int unsigned FRAME   = (NB + 2) * BC;   // 176
  localparam int unsigned BC_D    = 2604;
  localparam int unsigned FRAME_D = 28644;

  logic          clock = 1'b0;
  logic          reset_n, send, ready, tx, done;
  logic [NB-1:0] data;
  logic          reset_n_def, send_def, ready_def, tx_def, done_def;
  logic [NB-1:0] data_def;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [NB-1:0] exp_q[$];

  always #5 clock = ~clock;

  uart_tx #(.CLK_HZ(16), .BAUD_RATE(1), .DATA_BITS(NB)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .data    (data),
    .send    (send),
    .ready   (ready),
    .tx      (tx),
    .done    (done)
  );

  uart_tx dut_def (
    .clock   (clock),
    .reset_n (reset_n_def),
    .data    (data_def),
    .send    (send_def),
    .ready   (ready_def),
    .tx      (tx_def),
    .done    (done_def)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at the first negedge after the accepting edge; returns at the
  // negedge where done must be high (FRAME clocks after the accept).
  task automatic capture_frame(input string tag);
    logic [NB-1:0] exp_w;
    logic [NB-1:0] got;
    logic [BC-1:0] win;
    logic [BC-1:0] want;
    int            done_early;
    exp_w      = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    got        = '0;
    done_early = 0;
    for (int b = 0; b < int'(NB) + 2; b++) begin
      for (int c = 0; c < int'(BC); c++) begin
        win[c] = tx;
        if (done) done_early++;
        @(negedge clock);
      end
      if (b == 0)                 want = '0;
      else if (b == int'(NB) + 1) want = '1;
      else begin
        want           = {BC{exp_w[NB-b]}};
        got[NB-b]      = win[BC/2];
      end
      check($sformatf("%s_bit%0d", tag, b), 32'(win), 32'(want));
    end
    check({tag, "_data"},       32'(got),        32'(exp_w));
    check({tag, "_done_early"}, 32'(done_early), 32'd0);
    check({tag, "_done"},       32'(done),       32'd1);
    check({tag, "_gap_tx"},     32'(tx),         32'd1);
    check({tag, "_gap_ready"},  32'(ready),      32'd1);
  endtask

  // Sends one word on the default-rate instance and decodes it mid-bit.
  task automatic default_frame(input string tag, input logic [NB-1:0] w);
    logic [NB+1:0] bits;
    logic [NB-1:0] got;
    int            done_early;
    data_def = w;
    send_def = 1'b1;
    exp_q.push_back(w);
    @(negedge clock);
    send_def = 1'b0;
    data_def = ~w;
    check({tag, "_start_now"}, 32'(tx_def),    32'd0);
    check({tag, "_busy"},      32'(ready_def), 32'd0);
    bits       = '1;
    done_early = 0;
    for (int s = 0; s < int'(FRAME_D); s++) begin
      if (s % int'(BC_D) == int'(BC_D) / 2) bits[s / int'(BC_D)] = tx_def;
      if (done_def) done_early++;
      @(negedge clock);
    end
    for (int b = 1; b <= int'(NB); b++) got[NB-b] = bits[b];
    check({tag, "_start_bit"},  32'(bits[0]),    32'd0);
    check({tag, "_framing"},    32'(bits[NB+1]), 32'd1);
    check({tag, "_data"},       32'(got),        32'(exp_q.pop_front()));
    check({tag, "_done_early"}, 32'(done_early), 32'd0);
    check({tag, "_done"},       32'(done_def),   32'd1);
  endtask

  initial begin
    int cnt_done, cnt_tx_low, cnt_not_ready;

    reset_n     = 1'b0;
    send        = 1'b0;
    data        = '0;
    reset_n_def = 1'b0;
    send_def    = 1'b0;
    data_def    = '0;

    // Reset state.
    repeat (3) @(negedge clock);
    check("rst_tx",     32'(tx),     32'd1);
    check("rst_ready",  32'(ready),  32'd1);
    check("rst_done",   32'(done),   32'd0);
    check("rst_tx_def", 32'(tx_def), 32'd1);
    reset_n     = 1'b1;
    reset_n_def = 1'b1;
    repeat (2) @(negedge clock);
    check("post_rst_ready", 32'(ready), 32'd1);

    // 1. Basic frame.
    data = 9'h1A5;
    send = 1'b1;
    exp_q.push_back(9'h1A5);
    @(negedge clock);
    send = 1'b0;
    check("t1_ready_drop", 32'(ready), 32'd0);
    capture_frame("t1");
    repeat (5) @(negedge clock);

    // 2. Sends and data changes during a frame are ignored.
    data = 9'h1A5;
    send = 1'b1;
    exp_q.push_back(9'h1A5);
    @(negedge clock);
    send = 1'b0;
    fork
      capture_frame("t2");
      begin
        for (int i = 0; i < int'(FRAME) - 1; i++) begin
          data = (i % 2 == 0) ? 9'h000 : NB'($urandom);
          send = (i % 3 == 0);
          @(negedge clock);
        end
        send = 1'b0;
        data = 9'h000;
      end
    join
    cnt_done = 0;
    cnt_tx_low = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) cnt_done++;
      if (!tx)  cnt_tx_low++;
    end
    check("t2_single_done", 32'(cnt_done),   32'd0);
    check("t2_no_restart",  32'(cnt_tx_low), 32'd0);

    // 3. Back-to-back: send held high, second word accepted in the done cycle.
    data = 9'h155;
    send = 1'b1;
    exp_q.push_back(9'h155);
    exp_q.push_back(9'h0AA);
    @(negedge clock);
    data = 9'h0AA;
    capture_frame("t3a");
    @(negedge clock);
    send = 1'b0;
    capture_frame("t3b");
    repeat (5) @(negedge clock);

    // 4. Reset in the middle of the data phase.
    data = 9'h1A5;
    send = 1'b1;
    @(negedge clock);
    send = 1'b0;
    repeat (5 * BC + BC / 2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("t4_async_tx",    32'(tx),    32'd1);
    check("t4_async_ready", 32'(ready), 32'd1);
    check("t4_async_done",  32'(done),  32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    cnt_done = 0;
    cnt_tx_low = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (done) cnt_done++;
      if (!tx)  cnt_tx_low++;
    end
    check("t4_no_done", 32'(cnt_done),   32'd0);
    check("t4_line_hi", 32'(cnt_tx_low), 32'd0);
    data = 9'h1FF;
    send = 1'b1;
    exp_q.push_back(9'h1FF);
    @(negedge clock);
    send = 1'b0;
    capture_frame("t4");

    // 6. Idle line.
    cnt_done = 0;
    cnt_tx_low = 0;
    cnt_not_ready = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (done)   cnt_done++;
      if (!tx)    cnt_tx_low++;
      if (!ready) cnt_not_ready++;
    end
    check("t6_done",  32'(cnt_done),      32'd0);
    check("t6_tx",    32'(cnt_tx_low),    32'd0);
    check("t6_ready", 32'(cnt_not_ready), 32'd0);

    // 1 and 5 at the default rate, decoded by the receiver model.
    default_frame("def_1a5", 9'h1A5);
    repeat (3) @(negedge clock);
    default_frame("def_0f3", 9'h0F3);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
